// File: rtl/blink_word_shell_if.sv
// Host word stream and wide cipher-core buses for the Blink-128 host shell.
// The shell attaches through the slave modport. The environment (host adapter
// plus cipher core) attaches through the master modport.
interface blink_word_shell_if;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_sel;
    logic          in_enc;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          busy;
    logic          core_enc;
    logic [1279:0] core_K0;
    logic [765:0]  core_K1;
    logic [255:0]  core_T;
    logic [127:0]  core_P;
    logic [127:0]  core_C;

    modport slave (
        input  in_valid, in_sel, in_enc, in_data, out_ready, core_C,
        output in_ready, out_valid, out_data, busy,
        output core_enc, core_K0, core_K1, core_T, core_P
    );

    modport master (
        output in_valid, in_sel, in_enc, in_data, out_ready, core_C,
        input  in_ready, out_valid, out_data, busy,
        input  core_enc, core_K0, core_K1, core_T, core_P
    );
endinterface

// File: rtl/blink_word_shell.sv
// Word-serial host shell for the Blink-128 cipher core. The shell assembles K0,
// K1, T and P from 32-bit beats and launches one block per completed
// plaintext. It waits CORE_LAT cycles and then returns the 128-bit result as
// four words.
module blink_word_shell #(
    parameter int CORE_LAT = 2          // legal range 1..15
) (
    input logic           clk,
    input logic           rst,          // asynchronous, active-low
    blink_word_shell_if.slave bus
);

    localparam logic [3:0] LAT_LOAD = 4'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Select 32-bit word idx of a 128-bit block (word 0 = bits [31:0]).
    function automatic logic [31:0] f_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            2'd3:    w = blk[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t          r_state;
    logic [1279:0]   r_k0;
    logic [767:0]    r_k1;      // top 2 bits never reach the core
    logic [255:0]    r_t;
    logic [127:0]    r_p;
    logic [1:0]      r_pcnt;
    logic            r_enc;
    logic [3:0]      r_lat;
    logic [127:0]    r_res;
    logic [1:0]      r_idx;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [31:0]     r_out_data;
    logic            r_busy;

    logic            w_load_beat;
    logic            w_launch;
    logic            w_unused_k1;

    assign w_load_beat = (r_state == S_IDLE) && bus.in_valid && r_in_ready;
    assign w_launch    = w_load_beat && (bus.in_sel == 2'd3) && (r_pcnt == 2'd3);
    assign w_unused_k1 = ^r_k1[767:766];

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.core_enc  = r_enc;
    assign bus.core_K0   = r_k0;
    assign bus.core_K1   = r_k1[765:0];
    assign bus.core_T    = r_t;
    assign bus.core_P    = r_p;

    // Load datapath: shift the selected register right one word per IDLE beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k0   <= 1280'd0;
            r_k1   <= 768'd0;
            r_t    <= 256'd0;
            r_p    <= 128'd0;
            r_pcnt <= 2'd0;
            r_enc  <= 1'b0;
        end else if (w_load_beat) begin
            case (bus.in_sel)
                2'd0: r_k0 <= {bus.in_data, r_k0[1279:32]};
                2'd1: r_k1 <= {bus.in_data, r_k1[767:32]};
                2'd2: r_t  <= {bus.in_data, r_t[255:32]};
                2'd3: begin
                    r_p    <= {bus.in_data, r_p[127:32]};
                    r_pcnt <= r_pcnt + 2'd1;
                    if (r_pcnt == 2'd3) begin
                        r_enc <= bus.in_enc;
                    end
                end
                default: r_pcnt <= r_pcnt;
            endcase
        end
    end

    // Control FSM: wait out the core latency, capture the result, stream it out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lat       <= 4'd0;
            r_res       <= 128'd0;
            r_idx       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_lat      <= LAT_LOAD;
                        r_state    <= S_CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_lat == 4'd0) begin
                        r_res       <= bus.core_C;
                        r_idx       <= 2'd0;
                        r_out_data  <= bus.core_C[31:0];
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (r_idx == 2'd3) begin
                            r_idx       <= 2'd0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= 32'h0000_0000;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_out_data <= f_word(r_res, r_idx + 2'd1);
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_word_shell.sv
// Self-checking bench for blink_word_shell. A reference model tracks the key,
// tweak and plaintext registers. The modelled core returns C = P ^ T[127:0].
// Expected result words are queued at launch and popped as words leave the shell.
module tb_blink_word_shell;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    blink_word_shell_if bus_if();

    assign bus_if.core_C = bus_if.core_P ^ bus_if.core_T[127:0];

    blink_word_shell #(.CORE_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]   exp_q[$];
    logic [31:0]   exp_word;
    logic [1279:0] m_k0;
    logic [767:0]  m_k1;
    logic [255:0]  m_t;
    logic [127:0]  m_p;
    int            m_pcnt;
    logic [1279:0] k0_one;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        enc;
        logic        exp_busy;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [1279:0] act, input logic [1279:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic model_clear();
        m_k0   = '0;
        m_k1   = '0;
        m_t    = '0;
        m_p    = '0;
        m_pcnt = 0;
        exp_q.delete();
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] data, input logic enc);
        int t;
        t = 0;
        while (bus_if.in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) fail_now("send_in_ready");
        bus_if.in_valid = 1'b1;
        bus_if.in_sel   = sel;
        bus_if.in_data  = data;
        bus_if.in_enc   = enc;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        case (sel)
            2'd0: m_k0 = {data, m_k0[1279:32]};
            2'd1: m_k1 = {data, m_k1[767:32]};
            2'd2: m_t  = {data, m_t[255:32]};
            default: begin
                m_p    = {data, m_p[127:32]};
                m_pcnt = (m_pcnt + 1) % 4;
                if (m_pcnt == 0) begin
                    for (int i = 0; i < 4; i++) exp_q.push_back(m_p[32*i +: 32] ^ m_t[32*i +: 32]);
                end
            end
        endcase
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus_if.out_valid !== 1'b1 && t < 20);
        if (bus_if.out_valid !== 1'b1) fail_now("wait_out_valid");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && bus_if.in_ready === 1'b1 && bus_if.busy === 1'b0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) fail_now("wait_idle");
    endtask

    // Scoreboard: each accepted result word is compared with the queue head.
    always @(negedge clk) begin
        if (rst && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h expected no word", bus_if.out_data);
            end else begin
                exp_word = exp_q.pop_front();
                chk("out_word", 1280'(bus_if.out_data), 1280'(exp_word));
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_sel    = 2'd0;
        bus_if.in_data   = 32'h0;
        bus_if.in_enc    = 1'b0;
        bus_if.out_ready = 1'b1;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",  1280'(bus_if.in_ready),  1280'(1'b1));
        chk("rst_out_valid", 1280'(bus_if.out_valid), 1280'(1'b0));
        chk("rst_busy",      1280'(bus_if.busy),      1280'(1'b0));
        chk("rst_out_data",  1280'(bus_if.out_data),  1280'(32'h0));
        chk("rst_core_K0",   bus_if.core_K0,          1280'(0));
        chk("rst_core_P",    1280'(bus_if.core_P),    1280'(0));

        // K1 load ordering: words 0..23 then all-ones
        for (int i = 0; i < 24; i++) send(2'd1, 32'(i), 1'b0);
        send(2'd1, 32'hFFFF_FFFF, 1'b0);
        chk("k1_low",  1280'(bus_if.core_K1[31:0]),    1280'(32'h0000_0001));
        chk("k1_top",  1280'(bus_if.core_K1[765:736]), 1280'(30'h3FFF_FFFF));
        chk("k1_full", 1280'(bus_if.core_K1),          1280'(m_k1[765:0]));

        // Table: T words 1..8, then four P words with encrypt on the last
        for (int i = 0; i < 8; i++) vecs[i] = '{2'd2, 32'(i + 1), 1'b0, 1'b0, 1'b1};
        for (int i = 8; i < 11; i++) vecs[i] = '{2'd3, 32'h1111_1111, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'd3, 32'h1111_1111, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].sel, vecs[i].data, vecs[i].enc);
            chk("tbl_busy",     1280'(bus_if.busy),     1280'(vecs[i].exp_busy));
            chk("tbl_in_ready", 1280'(bus_if.in_ready), 1280'(vecs[i].exp_in_ready));
        end
        @(negedge clk);
        chk("lat_ov_c1", 1280'(bus_if.out_valid), 1280'(1'b0));
        @(negedge clk);
        chk("lat_ov_c2", 1280'(bus_if.out_valid), 1280'(1'b0));
        @(negedge clk);
        chk("lat_ov_c3", 1280'(bus_if.out_valid), 1280'(1'b1));
        chk("blk1_enc",  1280'(bus_if.core_enc),  1280'(1'b1));
        chk("blk1_T",    1280'(bus_if.core_T),    1280'(m_t));
        wait_idle();

        // Second block with P only: key reuse plus back-pressure on word 1
        send(2'd3, 32'hA5A5_A5A5, 1'b0);
        send(2'd3, 32'h5A5A_5A5A, 1'b0);
        send(2'd3, 32'h0F0F_0F0F, 1'b0);
        send(2'd3, 32'hF0F0_F0F0, 1'b0);
        wait_out_valid();
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_data", 1280'(bus_if.out_data),  1280'(exp_q[0]));
            chk("bp_in_ready",  1280'(bus_if.in_ready),  1280'(1'b0));
            chk("bp_out_valid", 1280'(bus_if.out_valid), 1280'(1'b1));
        end
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        wait_idle();
        chk("blk2_enc", 1280'(bus_if.core_enc), 1280'(1'b0));
        chk("blk2_K1",  1280'(bus_if.core_K1),  1280'(m_k1[765:0]));
        chk("blk2_T",   1280'(bus_if.core_T),   1280'(m_t));

        // Asynchronous reset while a result is waiting in OUT
        bus_if.out_ready = 1'b0;
        send(2'd0, 32'h1234_5678, 1'b0);
        send(2'd3, 32'h0000_0001, 1'b1);
        send(2'd3, 32'h0000_0002, 1'b1);
        send(2'd3, 32'h0000_0003, 1'b1);
        send(2'd3, 32'h0000_0004, 1'b1);
        wait_out_valid();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", 1280'(bus_if.out_valid), 1280'(1'b0));
        chk("ar_in_ready",  1280'(bus_if.in_ready),  1280'(1'b1));
        chk("ar_busy",      1280'(bus_if.busy),      1280'(1'b0));
        chk("ar_core_K0",   bus_if.core_K0,          1280'(0));
        chk("ar_core_T",    1280'(bus_if.core_T),    1280'(0));
        chk("ar_core_enc",  1280'(bus_if.core_enc),  1280'(1'b0));
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        bus_if.out_ready = 1'b1;

        // Interleaved K0 beat inside a P block; beats during CALC are ignored
        send(2'd3, 32'hAAAA_0000, 1'b0);
        send(2'd3, 32'hAAAA_0001, 1'b0);
        send(2'd0, 32'hCAFE_F00D, 1'b0);
        chk("il_busy_k0", 1280'(bus_if.busy), 1280'(1'b0));
        send(2'd3, 32'hAAAA_0002, 1'b0);
        chk("il_busy_p2", 1280'(bus_if.busy), 1280'(1'b0));
        send(2'd3, 32'hAAAA_0003, 1'b1);
        chk("il_busy_p3", 1280'(bus_if.busy), 1280'(1'b1));
        bus_if.in_valid = 1'b1;
        bus_if.in_sel   = 2'd0;
        bus_if.in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        k0_one = '0;
        k0_one[1279:1248] = 32'hCAFE_F00D;
        chk("il_core_K0",  bus_if.core_K0,          k0_one);
        chk("il_core_P",   1280'(bus_if.core_P),    1280'(m_p));
        chk("il_core_enc", 1280'(bus_if.core_enc),  1280'(1'b1));
        wait_idle();

        chk("sb_empty", 1280'(exp_q.size()), 1280'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
